// File: rtl/spi_reg_bridge_if.sv
// Bundle of the SPI pins and the per-register strobe bus around spi_reg_bridge.
//   slave  modport: the bridge (receives sclk/cs_n/mosi/rd_data, drives the rest)
//   master modport: the board / register side that drives the SPI pins and returns rd_data
//   sclk, cs_n, mosi   SPI inputs from the host MCU (asynchronous to clk)
//   miso, miso_oe      SPI data out and its output enable
//   wr_en, rd_en       one-hot single-cycle strobes, one bit per register slave
//   wr_data            write data, valid with wr_en and held afterwards
//   rd_data            OR of all slaves' read data (slaves drive 0 when not read)
//   xfer_done          one-cycle pulse per completed 16-bit transaction
interface spi_reg_bridge_if #(
    parameter int unsigned NUM_REGS = 4
) ();
    localparam int unsigned DATA_W = 8;

    logic                sclk;
    logic                cs_n;
    logic                mosi;
    logic                miso;
    logic                miso_oe;
    logic [NUM_REGS-1:0] wr_en;
    logic [NUM_REGS-1:0] rd_en;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W-1:0]   rd_data;
    logic                xfer_done;

    modport slave (
        input  sclk, cs_n, mosi, rd_data,
        output miso, miso_oe, wr_en, rd_en, wr_data, xfer_done
    );

    modport master (
        output sclk, cs_n, mosi, rd_data,
        input  miso, miso_oe, wr_en, rd_en, wr_data, xfer_done
    );
endinterface

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave to register-bus bridge. Decodes 2-byte frames (command byte
// {W, addr[6:0]} then data byte) into one-cycle one-hot wr_en/rd_en strobes and
// returns read data on MISO. SPI inputs are oversampled in the clk domain.
//   clk, reset_n   system clock, asynchronous active-low reset
//   bus (slave)    SPI pins, strobe bus and xfer_done (see spi_reg_bridge_if)
module spi_reg_bridge #(
    parameter int unsigned NUM_REGS    = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    spi_reg_bridge_if.slave bus
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_DONE
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q,   cs_prev_d;
    logic                   armed_q,     armed_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic [DATA_W-1:0]      rx_q,        rx_d;
    logic [DATA_W-1:0]      tx_q,        tx_d;
    logic [DATA_W-1:0]      cmd_q,       cmd_d;
    logic                   cap_q,       cap_d;
    logic                   miso_q,      miso_d;
    logic                   miso_oe_q,   miso_oe_d;
    logic [NUM_REGS-1:0]    wr_en_q,     wr_en_d;
    logic [NUM_REGS-1:0]    rd_en_q,     rd_en_d;
    logic [DATA_W-1:0]      wr_data_q,   wr_data_d;
    logic                   xfer_done_q, xfer_done_d;

    logic              sclk_s;
    logic              cs_n_s;
    logic              mosi_s;
    logic              sclk_rise;
    logic              sclk_fall;
    logic              cs_fall;
    logic [DATA_W-1:0] rx_next;

    // Address decode helpers.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] a);
        logic [NUM_REGS-1:0] oh;
        oh = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(a) == i) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    // Synchronized inputs and edge detects.
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_n_s    = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_n_s & cs_prev_q;
    assign rx_next   = {rx_q[DATA_W-2:0], mosi_s};

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_n_s;
        armed_d     = armed_q | cs_n_s;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        cmd_d       = cmd_q;
        cap_d       = |rd_en_q;
        miso_d      = 1'b0;
        // A frame already running when reset is released keeps MISO tri-stated.
        miso_oe_d   = armed_q & ~cs_n_s;
        wr_en_d     = '0;
        rd_en_d     = '0;
        wr_data_d   = wr_data_q;
        xfer_done_d = 1'b0;

        if (cs_fall) begin
            cnt_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (sclk_rise) begin
                    rx_d  = rx_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(7)) begin
                        state_d = ST_DATA;
                        cmd_d   = rx_next;
                        tx_d    = '0;
                        if (!rx_next[DATA_W-1] && addr_ok(rx_next[ADDR_W-1:0])) begin
                            rd_en_d = onehot(rx_next[ADDR_W-1:0]);
                        end
                    end
                end
            end
            ST_DATA: begin
                miso_d = miso_q;
                if (sclk_fall) begin
                    miso_d = tx_q[DATA_W-1];
                    tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                end
                if (sclk_rise) begin
                    rx_d  = rx_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(15)) begin
                        state_d     = ST_DONE;
                        miso_d      = 1'b0;
                        xfer_done_d = 1'b1;
                        if (cmd_q[DATA_W-1] && addr_ok(cmd_q[ADDR_W-1:0])) begin
                            wr_en_d   = onehot(cmd_q[ADDR_W-1:0]);
                            wr_data_d = rx_next;
                        end
                    end
                end
            end
            ST_DONE: begin
                // Extra edges are ignored until cs_n rises.
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Slave read latency is one cycle: data arrives the cycle after rd_en.
        if (cap_q) begin
            tx_d = bus.rd_data;
        end

        // cs_n high aborts from any state; nothing is committed in that cycle.
        if (cs_n_s) begin
            state_d     = ST_IDLE;
            miso_d      = 1'b0;
            wr_en_d     = '0;
            wr_data_d   = wr_data_q;
            rd_en_d     = '0;
            xfer_done_d = 1'b0;
        end
    end

    // State register. cs_n synchronizer and its history reset to "selected" so a
    // frame in progress at reset release never looks like a fresh falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
            armed_q     <= 1'b0;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            cmd_q       <= '0;
            cap_q       <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            wr_en_q     <= '0;
            rd_en_q     <= '0;
            wr_data_q   <= '0;
            xfer_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            armed_q     <= armed_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            cmd_q       <= cmd_d;
            cap_q       <= cap_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            wr_data_q   <= wr_data_d;
            xfer_done_q <= xfer_done_d;
        end
    end

    assign bus.miso      = miso_q;
    assign bus.miso_oe   = miso_oe_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.xfer_done = xfer_done_q;
endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: an SPI master task drives directed frames, a small
// register-slave environment answers reads, and a transaction-level model
// (register array + queue of expected strobe cycles) is checked every clk cycle.
module tb_spi_reg_bridge;
    localparam int unsigned NUM_REGS    = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int          HALF        = 8;                 // sclk half period in clk cycles
    localparam int          LAT         = SYNC_STAGES + 1;   // sclk edge drive -> strobe visible

    typedef struct {
        int         cyc;
        logic [3:0] wr;
        logic [3:0] rd;
        bit         done;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    spi_reg_bridge_if #(.NUM_REGS(NUM_REGS)) bus ();

    spi_reg_bridge #(
        .NUM_REGS   (NUM_REGS),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register slaves (environment): LED config at 0 resets to 0x5D, read latency 1.
    logic [7:0] slv [NUM_REGS];
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slv[0] <= 8'h5D;
            for (int i = 1; i < NUM_REGS; i++) slv[i] <= 8'h00;
            bus.rd_data <= 8'h00;
        end else begin
            logic [7:0] r;
            r = 8'h00;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bus.wr_en[i]) slv[i] <= bus.wr_data;
                if (bus.rd_en[i]) r = r | slv[i];
            end
            bus.rd_data <= r;
        end
    end

    // Reference model state.
    logic [7:0] exp_regs [NUM_REGS];
    exp_t       exp_q [$];
    logic [7:0] exp_wdata = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_regs[0] = 8'h5D;
        for (int i = 1; i < NUM_REGS; i++) exp_regs[i] = 8'h00;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Per-cycle compare of the strobe bus against the expected-event queue.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            exp_wdata = 8'h00;
        end else begin
            logic [3:0] ew;
            logic [3:0] er;
            bit         ed;
            ew = '0; er = '0; ed = 1'b0;
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                if (exp_q[0].cyc == cyc) begin
                    ew |= exp_q[0].wr;
                    er |= exp_q[0].rd;
                    ed |= exp_q[0].done;
                    if (exp_q[0].wr != 4'b0000) exp_wdata = exp_q[0].data;
                end
                void'(exp_q.pop_front());
            end
            chk("wr_en",     32'(bus.wr_en),     32'(ew));
            chk("rd_en",     32'(bus.rd_en),     32'(er));
            chk("xfer_done", 32'(bus.xfer_done), 32'(ed));
            chk("wr_data",   32'(bus.wr_data),   32'(exp_wdata));
            if (bus.xfer_done) done_cnt++;
        end
    end

    // SPI master frame: nbits < 16 aborts, rst_at >= 0 pulses reset_n before that bit.
    task automatic frame(input logic [7:0] cmd, input logic [7:0] wdat, input int nbits,
                         input int rst_at, input int gap, output logic [7:0] rbyte);
        logic [15:0] word;
        logic [7:0]  exp_rd;
        bit          live;
        bit          aok;
        int          t;
        exp_t        e;
        word   = {cmd, wdat};
        live   = 1'b1;
        rbyte  = 8'h00;
        aok    = (cmd[6:0] < 7'(NUM_REGS));
        exp_rd = aok ? exp_regs[cmd[1:0]] : 8'h00;
        bus.cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = word[15-i];
            tick(HALF);
            if (i == rst_at) begin
                reset_n = 1'b0;
                #1;
                chk("rst_miso",      32'(bus.miso),      32'h0);
                chk("rst_miso_oe",   32'(bus.miso_oe),   32'h0);
                chk("rst_wr_en",     32'(bus.wr_en),     32'h0);
                chk("rst_rd_en",     32'(bus.rd_en),     32'h0);
                chk("rst_wr_data",   32'(bus.wr_data),   32'h0);
                chk("rst_xfer_done", 32'(bus.xfer_done), 32'h0);
                tick(2);
                reset_n = 1'b1;
                model_reset();
                live = 1'b0;
            end
            chk("miso_oe_in_frame", 32'(bus.miso_oe), 32'(live));
            if (live && i < 8) chk("miso_cmd_phase", 32'(bus.miso), 32'h0);
            if (i >= 8) rbyte = {rbyte[6:0], bus.miso};
            bus.sclk = 1'b1;
            t = cyc;
            if (live && i == 7 && !cmd[7] && aok) begin
                e.cyc = t + LAT; e.wr = '0; e.rd = 4'b0001 << cmd[1:0]; e.done = 1'b0; e.data = 8'h00;
                exp_q.push_back(e);
            end
            if (live && i == 15) begin
                e.cyc = t + LAT; e.wr = '0; e.rd = '0; e.done = 1'b1; e.data = wdat;
                if (cmd[7] && aok) begin
                    e.wr = 4'b0001 << cmd[1:0];
                    exp_regs[cmd[1:0]] = wdat;
                end
                exp_q.push_back(e);
            end
            tick(HALF);
            bus.sclk = 1'b0;
        end
        tick(HALF);
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        tick(gap);
        chk("miso_oe_idle", 32'(bus.miso_oe), 32'h0);
        chk("miso_idle",    32'(bus.miso),    32'h0);
        if (live && nbits == 16 && !cmd[7]) chk("read_byte", 32'(rbyte), 32'(exp_rd));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        bus.sclk = 1'b0;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        model_reset();
        reset_n = 1'b0;
        tick(3);
        chk("reset_miso",      32'(bus.miso),      32'h0);
        chk("reset_miso_oe",   32'(bus.miso_oe),   32'h0);
        chk("reset_wr_en",     32'(bus.wr_en),     32'h0);
        chk("reset_rd_en",     32'(bus.rd_en),     32'h0);
        chk("reset_wr_data",   32'(bus.wr_data),   32'h0);
        chk("reset_xfer_done", 32'(bus.xfer_done), 32'h0);
        reset_n = 1'b1;
        tick(6);

        // LED config reset value, then write/readback of addr 0.
        frame(8'h00, 8'h00, 16, -1, 6, rb);
        chk("led_reset_value", 32'(rb), 32'h5D);
        frame(8'h80, 8'hA5, 16, -1, 6, rb);
        chk("wr_data_a5", 32'(bus.wr_data), 32'hA5);
        frame(8'h00, 8'h00, 16, -1, 6, rb);

        // Back-to-back write/read of addr 2 with minimum cs_n high time.
        frame(8'h82, 8'h3C, 16, -1, 4, rb);
        frame(8'h02, 8'h00, 16, -1, 6, rb);
        chk("readback_3c", 32'(rb), 32'h3C);

        // Out-of-range read and write.
        frame(8'h7F, 8'h00, 16, -1, 6, rb);
        chk("read_7f", 32'(rb), 32'h00);
        frame(8'h85, 8'h99, 16, -1, 6, rb);
        chk("wr_data_held", 32'(bus.wr_data), 32'h3C);

        // Abort after 12 bits, then a clean write to addr 1.
        frame(8'h83, 8'hC3, 12, -1, 6, rb);
        frame(8'h81, 8'h5A, 16, -1, 6, rb);
        frame(8'h01, 8'h00, 16, -1, 6, rb);
        chk("readback_5a", 32'(rb), 32'h5A);

        // Reset during byte 1 of a write; the next frames decode normally.
        frame(8'h83, 8'h77, 16, 10, 6, rb);
        frame(8'h83, 8'h42, 16, -1, 6, rb);
        frame(8'h03, 8'h00, 16, -1, 6, rb);
        chk("readback_42", 32'(rb), 32'h42);
        frame(8'h00, 8'h00, 16, -1, 6, rb);
        chk("led_after_reset", 32'(rb), 32'h5D);

        tick(8);
        chk("xfer_done_count", 32'(done_cnt), 32'd12);
        chk("pending_events",  32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_reg_bridge.md
# spi_reg_bridge

SPI slave (mode 0) to on-chip register-bus bridge. It decodes 2-byte SPI transactions from the board's host MCU into single-cycle per-register write and read strobes (`wr_en`/`rd_en`, 8-bit data) for the downstream register slaves, starting with the LED blink configuration register. It also returns read data on MISO. All logic runs in the `clk` domain; SPI inputs are oversampled.

## Interface
- `NUM_REGS`, 4: number of register slaves; one-hot strobe width; addresses 0..NUM_REGS-1 are valid.
- `SYNC_STAGES`, 2: synchronizer depth on `sclk`, `cs_n`, `mosi`.
- `clk`  in  1  system clock; must be ≥16× `sclk` frequency.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sclk`  in  1  SPI clock, asynchronous to `clk`, idle low.
- `cs_n`  in  1  SPI chip select, active low, asynchronous.
- `mosi`  in  1  SPI data in, MSB first.
- `miso`  out  1  SPI data out, MSB first.
- `miso_oe`  out  1  MISO output enable; high while synchronized `cs_n` is low.
- `wr_en`  out  NUM_REGS  one-hot write strobe, 1 cycle.
- `rd_en`  out  NUM_REGS  one-hot read strobe, 1 cycle.
- `wr_data`  out  8  write data; valid with `wr_en`, held until the next write.
- `rd_data`  in  8  OR of all slaves' `data_out`; slaves drive 0 when not read.
- `xfer_done`  out  1  1-cycle pulse when a complete 16-bit transaction is processed.

## Operation
- Frame: `cs_n` falls, then 16 `sclk` rising edges.
  - Byte 0 is the command: bit7 = W (1 = write, 0 = read), bits6:0 = address.
  - Byte 1 is the data: write data on MOSI, or read data on MISO.
- Synchronizers are SYNC_STAGES flops each. Edge detect uses the synchronized `sclk` against its registered copy.
- MOSI is sampled on a detected rising edge. MISO updates on a detected falling edge.
- Bit counter is 4 bits, cleared on the `cs_n` falling edge, incremented per rising edge.
- FSM states:
  - IDLE → CMD on synchronized `cs_n` low.
  - CMD → DATA after the 8th rising edge. The command is latched at this point.
  - DATA → DONE after the 16th rising edge.
  - DONE → IDLE on `cs_n` high.
  - Any state → IDLE on `cs_n` high (abort).
- Read, address < NUM_REGS:
  - On entering DATA, pulse `rd_en[addr]` for 1 cycle.
  - Capture `rd_data` into the TX shift register exactly 1 cycle after the pulse (slave read latency 1).
  - Drive bit7 on the 8th falling edge, then shift one bit per falling edge.
- Read, address ≥ NUM_REGS: no `rd_en`; the TX register is loaded with 0x00.
- Write:
  - On the 16th rising edge, if address < NUM_REGS, set `wr_data` to the received byte and pulse `wr_en[addr]` for 1 cycle, together with `xfer_done`.
  - Writes to addresses ≥ NUM_REGS are dropped; `xfer_done` still pulses.
- Read completion: `xfer_done` pulses on the 16th rising edge.
- Edges beyond 16 (in DONE) are ignored and MISO holds 0. No auto-increment.
- Abort (`cs_n` high before the 16th rising edge): no `wr_en`, no `xfer_done`. A `rd_en` already issued is not retracted.
- MISO is 0 during CMD, and 0 when `cs_n` is high.
- Reset values: `miso`=0, `miso_oe`=0, `wr_en`=0, `rd_en`=0, `wr_data`=0x00, `xfer_done`=0; FSM=IDLE; counter=0.
- Reset asserted mid-transaction clears everything immediately. The bridge waits for a fresh `cs_n` falling edge before decoding; a frame already in progress at reset release is ignored until `cs_n` goes high.

## Timing
- Input-to-edge-detect latency: SYNC_STAGES+1 `clk` cycles.
- `rd_en` is asserted 1 cycle after the 8th rising edge is detected.
- `rd_data` is captured 1 cycle after `rd_en`.
- MISO bit7 appears SYNC_STAGES+2 cycles after the 8th `sclk` falling edge. This is valid before the 9th rising edge when half-period ≥ 8 `clk`.
- `wr_en` and `xfer_done` are asserted 1 cycle after the 16th rising edge is detected.
- `wr_en` and `rd_en` are never high in the same cycle. At most one bit of each is set.
- Minimum `cs_n` high time between frames: 4 `clk` cycles. Back-to-back frames must both decode.

## Test plan
- Write addr 0x00, data 0xA5 → `wr_en`=4'b0001 for exactly 1 cycle, `wr_data`=0xA5, `xfer_done` pulses; no `rd_en`.
- After reset, read addr 0x00 against an LED config model (reset value 0x5D, latency 1) → `rd_en`=4'b0001 for 1 cycle; MISO shifts 0x5D MSB-first on byte 1.
- Write 0x3C to addr 0x02, then read addr 0x02 back-to-back (4-cycle gap) → `wr_en`=4'b0100; read returns 0x3C.
- Read addr 0x7F → no `rd_en`, MISO returns 0x00. Write addr 0x05 → no `wr_en`, `xfer_done` still pulses.
- Raise `cs_n` after 12 bits of a write → no `wr_en` and no `xfer_done`. The next full write to addr 0x01 (0x81) decodes correctly.
- Assert `reset_n` low during byte 1 of a write → all outputs 0 within the reset cycle. After release, the remainder of that frame yields no strobe; the next frame decodes.
